aclk_fsm: RTL
=============

ACLK_FSM -- requirements
Module: aclk_fsm

Interface
REQ-001 SHALL have port: clock  input  1  single system clock, all state updates on rising edge.
REQ-002 SHALL have port: reset_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port: one_second  input  1  one-cycle pulse, once per second.
REQ-004 SHALL have port: key  input  4  keypad code: 0x0-0x9 digit, 0xA ALARM, 0xB TIME, 0xF NOKEY, 0xC-0xE reserved.
REQ-005 SHALL have port: show_a  output  1  display alarm time (feeds LCD driver).
REQ-006 SHALL have port: show_new_time  output  1  display keyed-in digit (feeds LCD driver).
REQ-007 SHALL have port: shift  output  1  one-cycle strobe, shift key into entry register.
REQ-008 SHALL have port: load_new_a  output  1  one-cycle strobe, load entry into alarm register.
REQ-009 SHALL have port: load_new_c  output  1  one-cycle strobe, load entry into current-time counter.

Function
REQ-010 SHALL be a Moore FSM; outputs decoded from the state register only, valid the whole cycle the state is held.
REQ-011 SHALL implement states IDLE, SHOW_ALARM, KEY_STORED, KEY_WAITED, KEY_ENTRY, SET_ALARM_TIME, SET_CURRENT_TIME.
REQ-012 IDLE: key 0x0-0x9 -> KEY_STORED; key 0xA -> SHOW_ALARM; any other code -> stay; all outputs 0.
REQ-013 SHOW_ALARM: show_a=1; key 0xF -> IDLE; any other code -> stay.
REQ-014 KEY_STORED: shift=1, show_new_time=1; unconditionally -> KEY_WAITED next cycle; exactly one shift per key press.
REQ-015 KEY_WAITED: show_new_time=1; key 0xF -> KEY_ENTRY; timeout -> IDLE; else stay; release beats timeout when both occur in the same cycle.
REQ-016 KEY_ENTRY: show_new_time=1; digit -> KEY_STORED; 0xA -> SET_ALARM_TIME; 0xB -> SET_CURRENT_TIME; timeout -> IDLE; 0xC-0xF -> stay; a key beats timeout when both occur in the same cycle.
REQ-017 SET_ALARM_TIME: load_new_a=1 for exactly one cycle, then -> IDLE.
REQ-018 SET_CURRENT_TIME: load_new_c=1 for exactly one cycle, then -> IDLE.
REQ-019 show_a and show_new_time SHALL never both be 1; shift, load_new_a and load_new_c SHALL be mutually exclusive.
REQ-020 Timeout counter SHALL be 4 bits, increment on one_second only in KEY_WAITED/KEY_ENTRY, and clear on every entry into KEY_STORED and in every other state.
REQ-021 Timeout SHALL fire on the one_second pulse arriving with the counter at 9 (the 10th pulse); the counter never exceeds 9.
REQ-022 Reserved codes 0xC-0xE SHALL be ignored: no transition and no counter reset, and they are not treated as a release.
REQ-023 Unreachable state encodings SHALL recover to IDLE on the next clock.

Reset
REQ-024 reset_n=0 SHALL immediately force state IDLE, clear the timeout counter, and drive all five outputs to 0, independent of clock.
REQ-025 Reset asserted mid-entry SHALL abort the entry; no load strobe is issued after reset_n deasserts.
REQ-026 The first transition after reset_n deasserts SHALL occur on the first rising clock edge with reset_n=1.

Configuration
REQ-027 With macro ACLK_FSM_TIMEOUT_EN defined, REQ-020/021 timeout behaviour SHALL be compiled in.
REQ-028 Without ACLK_FSM_TIMEOUT_EN, the counter SHALL be absent, one_second is unused, and KEY_WAITED/KEY_ENTRY exit only on key events.

Verification
REQ-029 Reset, then key=0xA for 3 cycles, then key=0xF -> show_a=1 for 3 cycles, then IDLE with show_a=0.
REQ-030 key=0x5 for 4 cycles, then 0xF, then 0xA -> shift high exactly 1 cycle, show_new_time=1 throughout entry, load_new_a=1 exactly 1 cycle, then IDLE.
REQ-031 key=0x3, 0xF, 0x7, 0xF, 0xB -> two single-cycle shift pulses, then load_new_c=1 for 1 cycle, then IDLE.
REQ-032 (TIMEOUT_EN) key=0x2, 0xF, then 10 one_second pulses with key=0xF -> IDLE on the 10th pulse; no load strobe; with 9 pulses, remains in KEY_ENTRY.
REQ-033 (TIMEOUT_EN) in KEY_ENTRY with count=9, key=0x4 and one_second in the same cycle -> KEY_STORED, shift=1, counter cleared.
REQ-034 reset_n pulsed low while in KEY_WAITED between edges -> outputs 0 immediately; after release, key=0xA -> SHOW_ALARM; no load strobe seen.

Source files
------------

// File: rtl/aclk_fsm.sv
// rtl/aclk_fsm.sv - alarm clock keypad control FSM (optional timeout: ACLK_FSM_TIMEOUT_EN)
module aclk_fsm (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       one_second,
    input  logic [3:0] key,
    output logic       show_a,
    output logic       show_new_time,
    output logic       shift,
    output logic       load_new_a,
    output logic       load_new_c
);

    typedef enum logic [2:0] {
        IDLE             = 3'd0,
        SHOW_ALARM       = 3'd1,
        KEY_STORED       = 3'd2,
        KEY_WAITED       = 3'd3,
        KEY_ENTRY        = 3'd4,
        SET_ALARM_TIME   = 3'd5,
        SET_CURRENT_TIME = 3'd6
    } state_e;

    localparam logic [3:0] KEY_ALARM = 4'hA;
    localparam logic [3:0] KEY_TIME  = 4'hB;
    localparam logic [3:0] KEY_NONE  = 4'hF;

    state_e state_q, state_d;
    logic   show_a_d, show_new_time_d, shift_d, load_new_a_d, load_new_c_d;
    logic   is_digit;
    logic   timeout;

    assign is_digit = (key <= 4'd9);

`ifdef ACLK_FSM_TIMEOUT_EN
    logic [3:0] cnt_q, cnt_d;
    logic       in_entry_q, in_entry_d;

    assign timeout    = one_second && (cnt_q == 4'd9);
    assign in_entry_q = (state_q == KEY_WAITED) || (state_q == KEY_ENTRY);
    assign in_entry_d = (state_d == KEY_WAITED) || (state_d == KEY_ENTRY);

    // Count seconds only while staying inside the entry phase; saturate at 9 so a
    // release that beats the timeout leaves the next pulse to fire it.
    always_comb begin
        cnt_d = 4'd0;
        if (in_entry_q && in_entry_d) begin
            if (one_second && (cnt_q < 4'd9)) begin
                cnt_d = cnt_q + 4'd1;
            end else begin
                cnt_d = cnt_q;
            end
        end
    end

    // Timeout counter register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic unused_one_second;
    assign unused_one_second = one_second;
    assign timeout           = 1'b0;
`endif

    // Next-state logic; reserved codes fall through to "stay" everywhere.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (is_digit)               state_d = KEY_STORED;
                else if (key == KEY_ALARM)  state_d = SHOW_ALARM;
            end
            SHOW_ALARM: begin
                if (key == KEY_NONE)        state_d = IDLE;
            end
            KEY_STORED: begin
                state_d = KEY_WAITED;
            end
            KEY_WAITED: begin
                if (key == KEY_NONE)        state_d = KEY_ENTRY;
                else if (timeout)           state_d = IDLE;
            end
            KEY_ENTRY: begin
                if (is_digit)               state_d = KEY_STORED;
                else if (key == KEY_ALARM)  state_d = SET_ALARM_TIME;
                else if (key == KEY_TIME)   state_d = SET_CURRENT_TIME;
                else if (timeout)           state_d = IDLE;
            end
            SET_ALARM_TIME:                 state_d = IDLE;
            SET_CURRENT_TIME:               state_d = IDLE;
            default:                        state_d = IDLE;
        endcase
    end

    // Moore decode of the upcoming state so the registered outputs track state_q.
    always_comb begin
        show_a_d        = (state_d == SHOW_ALARM);
        show_new_time_d = (state_d == KEY_STORED) || (state_d == KEY_WAITED) ||
                          (state_d == KEY_ENTRY);
        shift_d         = (state_d == KEY_STORED);
        load_new_a_d    = (state_d == SET_ALARM_TIME);
        load_new_c_d    = (state_d == SET_CURRENT_TIME);
    end

    // State and registered outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            show_a        <= 1'b0;
            show_new_time <= 1'b0;
            shift         <= 1'b0;
            load_new_a    <= 1'b0;
            load_new_c    <= 1'b0;
        end else begin
            state_q       <= state_d;
            show_a        <= show_a_d;
            show_new_time <= show_new_time_d;
            shift         <= shift_d;
            load_new_a    <= load_new_a_d;
            load_new_c    <= load_new_c_d;
        end
    end

endmodule
